// File: rtl/floo_id_order_tracker.sv
// Per-ID ordering tracker: forwards a request only when its AXI ID has no
// in-flight transaction to another destination and no outstanding limit is hit.
module floo_id_order_tracker #(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned DestWidth    = 8,
    parameter int unsigned MaxTxnsPerId = 32,
    parameter int unsigned MaxTxnsTotal = 64,
    parameter bit          EnDestCheck  = 1'b1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               ax_valid_i,
    output logic                               ax_ready_o,
    input  logic [IdWidth-1:0]                 ax_id_i,
    input  logic [DestWidth-1:0]               ax_dest_i,
    output logic                               ax_valid_o,
    input  logic                               ax_ready_i,
    input  logic                               rsp_valid_i,
    input  logic                               rsp_ready_i,
    input  logic [IdWidth-1:0]                 rsp_id_i,
    input  logic                               rsp_last_i,
    output logic                               busy_o,
    output logic [$clog2(MaxTxnsTotal+1)-1:0]  total_cnt_o,
    output logic                               stall_dest_o,
    output logic                               stall_full_o
);

    localparam int unsigned NumIds   = 2 ** IdWidth;
    localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);
    localparam int unsigned TotWidth = $clog2(MaxTxnsTotal + 1);

    logic [CntWidth-1:0]  cnt_all  [NumIds];
    logic [DestWidth-1:0] dest_all [NumIds];
    logic [TotWidth-1:0]  tot_reg, tot_next;
    logic [CntWidth-1:0]  req_cnt, rsp_cnt;
    logic                 conflict, full, allow, push, pop;

    // Decisions use registered state only, so a pop never unblocks a request
    // in the same cycle and there is no combinational rsp->ax path.
    assign req_cnt  = cnt_all[ax_id_i];
    assign rsp_cnt  = cnt_all[rsp_id_i];
    assign conflict = EnDestCheck && (req_cnt != '0) && (dest_all[ax_id_i] != ax_dest_i);
    assign full     = (req_cnt == CntWidth'(MaxTxnsPerId)) || (tot_reg == TotWidth'(MaxTxnsTotal));
    assign allow    = !conflict && !full;

    assign ax_valid_o   = ax_valid_i && allow;
    assign ax_ready_o   = ax_ready_i && allow;
    assign stall_dest_o = ax_valid_i && conflict;
    assign stall_full_o = ax_valid_i && full && !conflict;

    assign push = ax_valid_i && allow && ax_ready_i;
    // A last beat for an idle ID (e.g. stale after reset) is dropped.
    assign pop  = rsp_valid_i && rsp_ready_i && rsp_last_i && (rsp_cnt != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NumIds; gi++) begin : g_entry
            logic                 inc, dec;
            logic [CntWidth-1:0]  cnt_reg, cnt_next;
            logic [DestWidth-1:0] dest_reg;

            assign inc = push && (ax_id_i == IdWidth'(gi));
            assign dec = pop && (rsp_id_i == IdWidth'(gi));

            always_comb begin
                cnt_next = cnt_reg;
                if (inc && !dec) begin
                    cnt_next = cnt_reg + CntWidth'(1);
                end else if (dec && !inc) begin
                    cnt_next = cnt_reg - CntWidth'(1);
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cnt_reg  <= '0;
                    dest_reg <= '0;
                end else begin
                    cnt_reg <= cnt_next;
                    if (inc) begin
                        dest_reg <= ax_dest_i;
                    end
                end
            end

            assign cnt_all[gi]  = cnt_reg;
            assign dest_all[gi] = dest_reg;
        end
    endgenerate

    always_comb begin
        tot_next = tot_reg;
        if (push && !pop) begin
            tot_next = tot_reg + TotWidth'(1);
        end else if (pop && !push) begin
            tot_next = tot_reg - TotWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tot_reg <= '0;
        end else begin
            tot_reg <= tot_next;
        end
    end

    assign busy_o      = (tot_reg != '0);
    assign total_cnt_o = tot_reg;

`ifndef SYNTHESIS
    int unsigned cnt_sum;
    always_comb begin
        cnt_sum = 0;
        for (int i = 0; i < int'(NumIds); i++) begin
            cnt_sum += 32'(cnt_all[i]);
        end
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (!rst_i) begin
            assert (cnt_sum == 32'(tot_reg))
                else $error("floo_id_order_tracker: global count %0d differs from per-ID sum %0d",
                            tot_reg, cnt_sum);
            assert (!(rsp_valid_i && rsp_ready_i && rsp_last_i) || (rsp_cnt != '0))
                else $warning("floo_id_order_tracker: last beat for idle ID %0d ignored", rsp_id_i);
        end
    end
`endif

endmodule

// File: tb/tb_floo_id_order_tracker.sv
// Bench for floo_id_order_tracker: two instances (dest check on / off, different
// limits) share one stimulus stream and are compared every cycle against a count model.
module tb_floo_id_order_tracker;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       ax_valid_i, ax_ready_i, rsp_valid_i, rsp_ready_i, rsp_last_i;
    logic [3:0] ax_id_i, rsp_id_i;
    logic [7:0] ax_dest_i;

    logic       vo [2];
    logic       ro [2];
    logic       busy [2];
    logic       sd [2];
    logic       sf [2];
    logic [2:0] tc [2];

    int vectors    = 0;
    int miscompares = 0;

    // Model: per-ID outstanding count and last pushed destination, per instance.
    int m_cnt  [2][16];
    int m_dest [2][16];
    int per_max [2] = '{3, 2};
    int tot_max [2] = '{5, 4};
    int en_dc   [2] = '{1, 0};

    always #5 clk_i = ~clk_i;

    floo_id_order_tracker #(
        .IdWidth(4), .DestWidth(8), .MaxTxnsPerId(3), .MaxTxnsTotal(5), .EnDestCheck(1'b1)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ax_valid_i(ax_valid_i), .ax_ready_o(ro[0]), .ax_id_i(ax_id_i), .ax_dest_i(ax_dest_i),
        .ax_valid_o(vo[0]), .ax_ready_i(ax_ready_i),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_i(rsp_ready_i), .rsp_id_i(rsp_id_i), .rsp_last_i(rsp_last_i),
        .busy_o(busy[0]), .total_cnt_o(tc[0]), .stall_dest_o(sd[0]), .stall_full_o(sf[0])
    );

    floo_id_order_tracker #(
        .IdWidth(4), .DestWidth(8), .MaxTxnsPerId(2), .MaxTxnsTotal(4), .EnDestCheck(1'b0)
    ) dut_nd (
        .clk_i(clk_i), .rst_i(rst_i),
        .ax_valid_i(ax_valid_i), .ax_ready_o(ro[1]), .ax_id_i(ax_id_i), .ax_dest_i(ax_dest_i),
        .ax_valid_o(vo[1]), .ax_ready_i(ax_ready_i),
        .rsp_valid_i(rsp_valid_i), .rsp_ready_i(rsp_ready_i), .rsp_id_i(rsp_id_i), .rsp_last_i(rsp_last_i),
        .busy_o(busy[1]), .total_cnt_o(tc[1]), .stall_dest_o(sd[1]), .stall_full_o(sf[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 16; i++) begin
                m_cnt[k][i]  = 0;
                m_dest[k][i] = 0;
            end
    endtask

    always @(posedge rst_i) model_clear();

    // Compare process: mid-cycle, inputs and registered state are stable.
    always @(negedge clk_i) begin
        int tot, conflict, full, allow, push, pop;
        if (rst_i) model_clear();
        for (int k = 0; k < 2; k++) begin
            tot = 0;
            for (int i = 0; i < 16; i++) tot += m_cnt[k][i];
            conflict = (en_dc[k] != 0 && m_cnt[k][ax_id_i] != 0 && m_dest[k][ax_id_i] != int'(ax_dest_i)) ? 1 : 0;
            full     = (m_cnt[k][ax_id_i] == per_max[k] || tot == tot_max[k]) ? 1 : 0;
            allow    = (conflict == 0 && full == 0) ? 1 : 0;
            chk($sformatf("ax_valid_o[%0d]", k),   vo[k],   (ax_valid_i && allow != 0) ? 1 : 0);
            chk($sformatf("ax_ready_o[%0d]", k),   ro[k],   (ax_ready_i && allow != 0) ? 1 : 0);
            chk($sformatf("stall_dest_o[%0d]", k), sd[k],   (ax_valid_i && conflict != 0) ? 1 : 0);
            chk($sformatf("stall_full_o[%0d]", k), sf[k],   (ax_valid_i && full != 0 && conflict == 0) ? 1 : 0);
            chk($sformatf("busy_o[%0d]", k),       busy[k], (tot != 0) ? 1 : 0);
            chk($sformatf("total_cnt_o[%0d]", k),  tc[k],   tot);
            if (!rst_i) begin
                push = (ax_valid_i && ax_ready_i && allow != 0) ? 1 : 0;
                pop  = (rsp_valid_i && rsp_ready_i && rsp_last_i && m_cnt[k][rsp_id_i] > 0) ? 1 : 0;
                if (pop != 0) m_cnt[k][rsp_id_i]--;
                if (push != 0) begin
                    m_cnt[k][ax_id_i]++;
                    m_dest[k][ax_id_i] = int'(ax_dest_i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ax_idle();
        ax_valid_i = 1'b0; ax_ready_i = 1'b0; ax_id_i = '0; ax_dest_i = '0;
    endtask

    task automatic rsp_idle();
        rsp_valid_i = 1'b0; rsp_ready_i = 1'b0; rsp_last_i = 1'b0; rsp_id_i = '0;
    endtask

    task automatic req(input int id, input int dst, input logic rdy);
        ax_valid_i = 1'b1; ax_id_i = 4'(id); ax_dest_i = 8'(dst); ax_ready_i = rdy;
    endtask

    task automatic rsp(input int id, input logic last, input logic rdy);
        rsp_valid_i = 1'b1; rsp_id_i = 4'(id); rsp_last_i = last; rsp_ready_i = rdy;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        ax_idle();
        rsp_idle();
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        int cand[$];
        rst_i = 1'b0;
        ax_idle();
        rsp_idle();
        #2;
        do_reset();
        chk("reset busy a", busy[0], 0);
        chk("reset total a", tc[0], 0);
        chk("reset total b", tc[1], 0);

        // Three pushes on ID 3, then three last-beat pops.
        req(3, 5, 1'b1);
        repeat (3) tick();
        ax_idle();
        chk("t1 total a", tc[0], 3);
        chk("t1 total b", tc[1], 2);
        rsp(3, 1'b1, 1'b1);
        repeat (3) tick();
        rsp_idle();
        chk("t1 drained total a", tc[0], 0);
        chk("t1 drained busy a", busy[0], 0);

        // Destination conflict on ID 2.
        do_reset();
        req(2, 1, 1'b1);
        tick();
        req(2, 4, 1'b0);
        #1;
        chk("t2 stall_dest a", sd[0], 1);
        chk("t2 valid_o a", vo[0], 0);
        chk("t2 stall_dest nodc", sd[1], 0);
        chk("t2 valid_o nodc", vo[1], 1);
        rsp(2, 1'b1, 1'b1);
        #1;
        chk("t2 pop same cycle still stalled", sd[0], 1);
        tick();
        rsp_idle();
        #1;
        chk("t2 valid_o after pop", vo[0], 1);
        chk("t2 stall_dest after pop", sd[0], 0);
        ax_idle();

        // Per-ID limit (instance b: 2 per ID).
        do_reset();
        req(0, 7, 1'b1);
        repeat (2) tick();
        ax_ready_i = 1'b0;
        #1;
        chk("t3 stall_full b", sf[1], 1);
        chk("t3 stall_full a", sf[0], 0);
        rsp(0, 1'b1, 1'b1);
        ax_ready_i = 1'b1;
        #1;
        chk("t3 stall_full b during pop", sf[1], 1);
        tick();
        rsp_idle();
        #1;
        chk("t3 push+pop total a", tc[0], 2);
        chk("t3 total b after pop", tc[1], 1);
        chk("t3 valid_o b cycle after pop", vo[1], 1);
        tick();
        ax_idle();
        chk("t3 total b refilled", tc[1], 2);
        chk("t3 total a", tc[0], 3);

        // Global limit (instance b: 4 total).
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req(i, i, 1'b1);
            tick();
        end
        req(4, 9, 1'b0);
        #1;
        chk("t4 stall_full b", sf[1], 1);
        chk("t4 stall_dest b", sd[1], 0);
        chk("t4 valid_o a", vo[0], 1);
        ax_idle();

        // Multi-beat response on ID 1.
        do_reset();
        req(1, 2, 1'b1);
        repeat (2) tick();
        ax_idle();
        rsp(1, 1'b0, 1'b1);
        tick();
        chk("t5 non-last beat", tc[0], 2);
        rsp(1, 1'b1, 1'b0);
        tick();
        chk("t5 not-ready beat", tc[0], 2);
        rsp(1, 1'b1, 1'b1);
        tick();
        rsp_idle();
        chk("t5 last beat a", tc[0], 1);
        chk("t5 last beat b", tc[1], 1);

        // Asynchronous reset with traffic outstanding, then a stale pop.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            req(i, 3, 1'b1);
            tick();
        end
        ax_idle();
        chk("t6 total a", tc[0], 5);
        chk("t6 total b", tc[1], 4);
        #1;
        rst_i = 1'b1;
        #1;
        chk("t6 async busy a", busy[0], 0);
        chk("t6 async total a", tc[0], 0);
        chk("t6 async total b", tc[1], 0);
        #1;
        rst_i = 1'b0;
        tick();
        rsp(3, 1'b1, 1'b1);
        tick();
        rsp_idle();
        chk("t6 stale pop total a", tc[0], 0);
        chk("t6 stale pop busy b", busy[1], 0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int n = 0; n < 3000; n++) begin
            rst_i       = ($urandom_range(399) == 0);
            ax_valid_i  = ($urandom_range(9) < 7);
            ax_ready_i  = ($urandom_range(3) != 0);
            ax_id_i     = 4'($urandom_range(7));
            ax_dest_i   = 8'($urandom_range(3));
            rsp_valid_i = ($urandom_range(1) == 1);
            rsp_ready_i = ($urandom_range(4) != 0);
            rsp_last_i  = ($urandom_range(4) < 3);
            cand.delete();
            for (int i = 0; i < 8; i++)
                if (m_cnt[0][i] > 0 && m_cnt[1][i] > 0) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(9) < 8)
                rsp_id_i = 4'(cand[$urandom_range(cand.size() - 1)]);
            else
                rsp_id_i = 4'($urandom_range(7));
            tick();
        end
        rst_i = 1'b0;
        ax_idle();
        rsp_idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
